// File: rtl/scudsp_pkg.sv
// Shared types and helpers for the SCU DSP DMA sequencer.
package scudsp_pkg;

   typedef enum logic [2:0] {
      DMA_IDLE,
      DMA_RRD,
      DMA_BUS,
      DMA_WR,
      DMA_DONE
   } dma_state_e;

   typedef struct packed {
      logic       dir;
      logic [1:0] rams;
      logic       prgw;
      logic       hold;
      logic [8:0] step;
   } dma_cmd_t;

   // ADDI code n>0 selects a byte step of 2^(n+1); code 0 keeps the address fixed.
   function automatic logic [8:0] dma_step(input logic [2:0] addi);
      logic [3:0] sh;
      sh = {1'b0, addi} + 4'd1;
      return (addi == 3'd0) ? 9'd0 : (9'd1 << sh);
   endfunction

   function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
      return 4'b0001 << bank;
   endfunction

endpackage

// File: rtl/scudsp_dma_seq.sv
// SCU DSP DMA sequencer: moves words between the D0 bus and DSP DATA/program RAM,
// one bus request per word, with RA0/WA0 writeback and the T0 busy flag.
module scudsp_dma_seq
   import scudsp_pkg::*;
#(
   parameter int ADDR_W = 27
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              start,
   input  logic              dir,
   input  logic [1:0]        rams,
   input  logic              prgw,
   input  logic              hold,
   input  logic [2:0]        addi,
   input  logic [7:0]        cnt,
   input  logic [ADDR_W-3:0] ra0,
   input  logic [ADDR_W-3:0] wa0,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_a,
   output logic [31:0]       bus_do,
   input  logic [31:0]       bus_di,
   input  logic              bus_ack,
   output logic [3:0]        ram_we,
   output logic [3:0]        ram_re,
   output logic [31:0]       ram_d,
   input  logic [31:0]       ram_q,
   output logic [3:0]        ct_inc,
   output logic              prg_we,
   output logic [7:0]        prg_a,
   output logic [ADDR_W-3:0] ra0_out,
   output logic [ADDR_W-3:0] wa0_out,
   output logic              ra0_upd,
   output logic              wa0_upd,
   output logic              busy
);

   dma_state_e        state, state_nx;
   dma_cmd_t          cmd, cmd_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic [8:0]        words_left, words_left_nx;
   logic [7:0]        prg_addr, prg_addr_nx;
   logic [31:0]       data_buf, data_buf_nx;
   logic              first_rd, first_rd_nx;
   logic [3:0]        bank_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= DMA_IDLE;
         cmd        <= '0;
         addr       <= '0;
         words_left <= '0;
         prg_addr   <= '0;
         data_buf   <= '0;
         first_rd   <= 1'b0;
      end else if (ce) begin
         state      <= state_nx;
         cmd        <= cmd_nx;
         addr       <= addr_nx;
         words_left <= words_left_nx;
         prg_addr   <= prg_addr_nx;
         data_buf   <= data_buf_nx;
         first_rd   <= first_rd_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      cmd_nx        = cmd;
      addr_nx       = addr;
      words_left_nx = words_left;
      prg_addr_nx   = prg_addr;
      data_buf_nx   = data_buf;
      first_rd_nx   = 1'b0;
      unique case (state)
         DMA_IDLE: begin
            if (start) begin
               cmd_nx        = '{dir: dir, rams: rams, prgw: prgw & ~dir,
                                 hold: hold, step: dma_step(addi)};
               addr_nx       = {(dir ? wa0 : ra0), 2'b00};
               words_left_nx = {(cnt == 8'd0), cnt};
               prg_addr_nx   = '0;
               state_nx      = dir ? DMA_RRD : DMA_BUS;
            end
         end
         DMA_RRD: begin
            state_nx    = DMA_BUS;
            first_rd_nx = 1'b1;
         end
         DMA_BUS: begin
            // RAM_Q is only valid on the first bus cycle; hold it for the rest of the request.
            if (cmd.dir && first_rd)
               data_buf_nx = ram_q;
            if (bus_ack) begin
               addr_nx = addr + {{(ADDR_W-9){1'b0}}, cmd.step};
               if (!cmd.dir) begin
                  data_buf_nx = bus_di;
                  state_nx    = DMA_WR;
               end else begin
                  words_left_nx = words_left - 9'd1;
                  state_nx      = (words_left == 9'd1) ? DMA_DONE : DMA_RRD;
               end
            end
         end
         DMA_WR: begin
            words_left_nx = words_left - 9'd1;
            if (cmd.prgw)
               prg_addr_nx = prg_addr + 8'd1;
            state_nx = (words_left == 9'd1) ? DMA_DONE : DMA_BUS;
         end
         DMA_DONE: state_nx = DMA_IDLE;
         default:  state_nx = DMA_IDLE;
      endcase
   end

   assign bank_sel = bank_onehot(cmd.rams);

   assign busy    = (state != DMA_IDLE);
   assign bus_req = (state == DMA_BUS);
   assign bus_we  = bus_req & cmd.dir;
   assign bus_a   = addr;
   assign bus_do  = bus_we ? (first_rd ? ram_q : data_buf) : 32'd0;
   assign ram_d   = data_buf;
   assign ram_we  = (state == DMA_WR && !cmd.prgw) ? bank_sel : 4'd0;
   assign ram_re  = (state == DMA_RRD) ? bank_sel : 4'd0;
   assign ct_inc  = ram_we | ram_re;
   assign prg_we  = (state == DMA_WR) & cmd.prgw;
   assign prg_a   = prg_addr;
   assign ra0_out = addr[ADDR_W-1:2];
   assign wa0_out = addr[ADDR_W-1:2];
   assign ra0_upd = (state == DMA_DONE) & ~cmd.hold & ~cmd.dir;
   assign wa0_upd = (state == DMA_DONE) & ~cmd.hold & cmd.dir;

endmodule

// File: tb/tb_scudsp_dma_seq.sv
// Scoreboard bench for scudsp_dma_seq: bus/RAM responders, expected words queued at launch
// and compared as the sequencer completes bus words, RAM writes and pointer writebacks.
module tb_scudsp_dma_seq;

   localparam int AW = 27;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b1;
   logic          start = 1'b0;
   logic          dir = 1'b0;
   logic [1:0]    rams = 2'd0;
   logic          prgw = 1'b0;
   logic          hold = 1'b0;
   logic [2:0]    addi = 3'd0;
   logic [7:0]    cnt = 8'd0;
   logic [AW-3:0] ra0 = '0;
   logic [AW-3:0] wa0 = '0;
   logic [31:0]   bus_di = 32'd0;
   logic          bus_ack = 1'b0;
   logic [31:0]   ram_q = 32'd0;

   logic          bus_req, bus_we, prg_we, ra0_upd, wa0_upd, busy;
   logic [AW-1:0] bus_a;
   logic [31:0]   bus_do, ram_d;
   logic [3:0]    ram_we, ram_re, ct_inc;
   logic [7:0]    prg_a;
   logic [AW-3:0] ra0_out, wa0_out;

   scudsp_dma_seq #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .dir(dir), .rams(rams),
      .prgw(prgw), .hold(hold), .addi(addi), .cnt(cnt), .ra0(ra0), .wa0(wa0),
      .bus_req(bus_req), .bus_we(bus_we), .bus_a(bus_a), .bus_do(bus_do),
      .bus_di(bus_di), .bus_ack(bus_ack), .ram_we(ram_we), .ram_re(ram_re),
      .ram_d(ram_d), .ram_q(ram_q), .ct_inc(ct_inc), .prg_we(prg_we), .prg_a(prg_a),
      .ra0_out(ra0_out), .wa0_out(wa0_out), .ra0_upd(ra0_upd), .wa0_upd(wa0_upd),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic we; logic [AW-1:0] a; logic [31:0] d; } bus_exp_t;
   typedef struct { logic [1:0] bank; logic [31:0] d; } ram_exp_t;
   typedef struct { logic d; logic [AW-3:0] v; } upd_exp_t;

   bus_exp_t   exp_bus[$];
   ram_exp_t   exp_ram[$];
   logic [7:0] exp_prg[$];
   upd_exp_t   exp_upd[$];

   int n_chk = 0;
   int n_pass = 0;
   int ack_delay = 0;
   bit stray = 1'b0;
   bit ce_rand = 1'b0;
   int rdcnt[4];
   int waitc = 0;
   int step_tbl[8] = '{0, 4, 8, 16, 32, 64, 128, 256};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] ram_pat(input int b, input int k);
      return 32'hC0DE0000 | (32'(b) << 12) | 32'(k);
   endfunction

   // Bus slave, DATA RAM and CE source
   logic       req_e, ack_e, ce_e;
   logic [3:0] re_e;
   always @(posedge clk) begin
      req_e = bus_req;
      ack_e = bus_ack;
      ce_e  = ce;
      re_e  = ram_re;
      #1;
      if (rst_n && ce_e) begin
         for (int b = 0; b < 4; b++)
            if (re_e[b]) begin
               ram_q = ram_pat(b, rdcnt[b]);
               rdcnt[b]++;
            end
      end
      if (!rst_n) waitc = 0;
      else if (ce_e && req_e) waitc = ack_e ? 0 : waitc + 1;
      ce      = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_ack = bus_req ? (waitc >= ack_delay) : stray;
      bus_di  = {5'h15, bus_a};
   end

   // Monitor: compare each completed event against the head of its queue
   bus_exp_t be;
   ram_exp_t re;
   upd_exp_t ue;
   logic [7:0] pe;
   always @(negedge clk) begin
      if (rst_n && ce) begin
         if (bus_req && bus_ack) begin
            check_eq("bus_pending", 64'(exp_bus.size() != 0), 64'd1);
            if (exp_bus.size() != 0) begin
               be = exp_bus.pop_front();
               check_eq("bus_a", 64'(bus_a), 64'(be.a));
               check_eq("bus_we", 64'(bus_we), 64'(be.we));
               if (be.we) check_eq("bus_do", 64'(bus_do), 64'(be.d));
            end
         end
         if (|ram_re) check_eq("ct_inc_rd", 64'(ct_inc), 64'(ram_re));
         if (|ram_we) begin
            check_eq("ram_pending", 64'(exp_ram.size() != 0), 64'd1);
            if (exp_ram.size() != 0) begin
               re = exp_ram.pop_front();
               check_eq("ram_we", 64'(ram_we), 64'(4'b0001 << re.bank));
               check_eq("ct_inc_wr", 64'(ct_inc), 64'(4'b0001 << re.bank));
               check_eq("ram_d", 64'(ram_d), 64'(re.d));
            end
         end
         if (prg_we) begin
            check_eq("prg_pending", 64'(exp_prg.size() != 0), 64'd1);
            check_eq("prg_no_ct", 64'(ct_inc), 64'd0);
            if (exp_prg.size() != 0) begin
               pe = exp_prg.pop_front();
               check_eq("prg_a", 64'(prg_a), 64'(pe));
            end
         end
         if (ra0_upd || wa0_upd) begin
            check_eq("upd_pending", 64'(exp_upd.size() != 0), 64'd1);
            if (exp_upd.size() != 0) begin
               ue = exp_upd.pop_front();
               check_eq("upd_sel", 64'({ra0_upd, wa0_upd}), ue.d ? 64'd1 : 64'd2);
               check_eq("upd_val", 64'(ue.d ? wa0_out : ra0_out), 64'(ue.v));
            end
         end
      end
   end

   task automatic launch(input bit d, input logic [1:0] rb, input bit pw, input bit hd,
                         input logic [2:0] ai, input logic [7:0] cn,
                         input logic [AW-3:0] r0, input logic [AW-3:0] w0);
      logic [AW-1:0] a;
      int n;
      a = d ? {w0, 2'b00} : {r0, 2'b00};
      n = (cn == 8'd0) ? 256 : int'(cn);
      for (int b = 0; b < 4; b++) rdcnt[b] = 0;
      for (int k = 0; k < n; k++) begin
         exp_bus.push_back('{we: d, a: a, d: ram_pat(int'(rb), k)});
         if (!d) begin
            if (pw) exp_prg.push_back(8'(k));
            else    exp_ram.push_back('{bank: rb, d: {5'h15, a}});
         end
         a = a + AW'(step_tbl[ai]);
      end
      if (!hd) exp_upd.push_back('{d: d, v: a[AW-1:2]});
      dir = d; rams = rb; prgw = pw; hold = hd; addi = ai; cnt = cn; ra0 = r0; wa0 = w0;
      start = 1'b1;
      do begin
         @(posedge clk);
      end while (!ce);
      #2;
      start = 1'b0;
      check_eq("busy_rise", 64'(busy), 64'd1);
      check_eq("first_req", 64'(bus_req), 64'(!d));
      check_eq("first_re", 64'(ram_re), d ? 64'(4'b0001 << rb) : 64'd0);
   endtask

   task automatic finish_xfer(input int budget, input bit extra);
      int cyc;
      bit fired;
      cyc = 0;
      while (busy && cyc < budget) begin
         @(posedge clk);
         fired = start && ce;
         cyc++;
         #2;
         if (fired) start = 1'b0;
         if (extra && cyc == 4) begin
            cnt = 8'd5;
            dir = 1'b0;
            start = 1'b1;
         end
      end
      start = 1'b0;
      check_eq("busy_fall", 64'(busy), 64'd0);
      check_eq("bus_left", 64'(exp_bus.size()), 64'd0);
      check_eq("ram_left", 64'(exp_ram.size()), 64'd0);
      check_eq("prg_left", 64'(exp_prg.size()), 64'd0);
      check_eq("upd_left", 64'(exp_upd.size()), 64'd0);
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_req"}, 64'({bus_req, bus_we}), 64'd0);
      check_eq({tag, "_strobes"}, 64'({ram_we, ram_re, ct_inc, prg_we, ra0_upd, wa0_upd}), 64'd0);
      check_eq({tag, "_bus_a"}, 64'(bus_a), 64'd0);
      check_eq({tag, "_prg_a"}, 64'(prg_a), 64'd0);
      check_eq({tag, "_bus_do"}, 64'(bus_do), 64'd0);
   endtask

   initial begin
      #12;
      check_quiet("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // D0 -> RAM bank 1, immediate ACK
      ack_delay = 0;
      launch(1'b0, 2'd1, 1'b0, 1'b0, 3'd1, 8'd3, 25'h100, 25'h0);
      finish_xfer(200, 1'b0);

      // RAM -> D0 bank 2, fixed address, HOLD, slow ACK and stray ACKs while idle/reading
      ack_delay = 3;
      stray = 1'b1;
      launch(1'b1, 2'd2, 1'b0, 1'b1, 3'd0, 8'd2, 25'h0, 25'h40);
      finish_xfer(200, 1'b0);
      stray = 1'b0;

      // Program RAM load, CNT=0 means 256 words
      ack_delay = 0;
      launch(1'b0, 2'd0, 1'b1, 1'b0, 3'd1, 8'd0, 25'h10, 25'h0);
      finish_xfer(2000, 1'b0);

      // Address wrap at the top of the 27-bit space
      launch(1'b0, 2'd0, 1'b0, 1'b0, 3'd7, 8'd2, 25'h1FFFFFF, 25'h0);
      finish_xfer(200, 1'b0);

      // Reset mid-transfer: everything drops, no writeback
      ack_delay = 1;
      launch(1'b1, 2'd1, 1'b0, 1'b0, 3'd1, 8'd10, 25'h0, 25'h200);
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_quiet("midrst");
      exp_bus.delete();
      exp_ram.delete();
      exp_prg.delete();
      exp_upd.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      launch(1'b0, 2'd3, 1'b0, 1'b0, 3'd2, 8'd4, 25'h3000, 25'h0);
      finish_xfer(200, 1'b0);

      // CE toggling, PRGW ignored for RAM -> D0, second START while busy
      ack_delay = 2;
      ce_rand = 1'b1;
      launch(1'b1, 2'd0, 1'b1, 1'b0, 3'd3, 8'd6, 25'h0, 25'h1234);
      finish_xfer(1000, 1'b1);
      ce_rand = 1'b0;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/scudsp_dma_seq.md
# scudsp_dma_seq

Sequencer for the SCU DSP DMA instruction. It takes a decoded DMA start (direction, DATA RAM bank or program RAM target, transfer count, address step, hold) and moves words between the external D0 bus and DSP DATA/program RAM. It issues one bus request per word, drives RAM write/read strobes and CT increment pulses, and writes back RA0/WA0 on completion unless HOLD is set. It sits between the DSP decode/execute stage and the SCU A/B-bus arbiter, and provides the DSP T0 (DMA busy) flag.

## Interface
- ADDR_W, 27: external byte-address width; RA0/WA0 are word pointers of ADDR_W-2 bits.
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE  in  1  clock enable; all state advances only when CE=1
- START  in  1  one-CE-cycle pulse from decode (DMA.ST)
- DIR  in  1  0: D0→RAM, 1: RAM→D0
- RAMS  in  2  DATA RAM bank
- PRGW  in  1  D0→program RAM (DIR=0 only)
- HOLD  in  1  1: suppress RA0/WA0 writeback
- ADDI  in  3  address-step code (0,4,8,…,256 bytes via package step function)
- CNT  in  8  word count, 0 = 256
- RA0, WA0  in  ADDR_W-2  current read/write pointers
- BUS_REQ  out  1; BUS_WE  out  1; BUS_A  out  ADDR_W; BUS_DO  out  32
- BUS_DI  in  32; BUS_ACK  in  1  word completes on cycle ACK=1 while BUS_REQ=1
- RAM_WE  out  4  one-hot bank write; RAM_RE  out  4  one-hot bank read
- RAM_D  out  32; RAM_Q  in  32  (read data valid 1 CE cycle after RAM_RE)
- CT_INC  out  4  one-hot CT increment pulse, one per RAM word
- PRG_WE  out  1; PRG_A  out  8
- RA0_OUT, WA0_OUT  out  ADDR_W-2; RA0_UPD, WA0_UPD  out  1  writeback strobes
- BUSY  out  1  T0 flag

## Operation
- States: IDLE, RRD (RAM read), BUS (request outstanding), WR (RAM/PRG write), DONE.
- START in IDLE latches all inputs: addr ← {RA0 or WA0 (by DIR), 2'b00}, step ← step(ADDI), cnt (9-bit) ← {CNT==0, CNT}, PRG_A ← 0; BUSY←1. START while BUSY is ignored.
- D0→RAM: BUS → on ACK capture BUS_DI, addr += step → WR: pulse RAM_WE[RAMS]+CT_INC[RAMS] (or PRG_WE, PRG_A++), cnt-- → BUS, or DONE if cnt reaches 0.
- RAM→D0: RRD pulses RAM_RE[RAMS]+CT_INC[RAMS] → BUS with BUS_WE=1, BUS_DO=RAM_Q (registered) → on ACK addr += step, cnt-- → RRD, or DONE if cnt reaches 0.
- DONE: if HOLD=0, pulse RA0_UPD (DIR=0) or WA0_UPD (DIR=1) with OUT=addr[ADDR_W-1:2]; BUSY←0 → IDLE.
- Address wraps modulo 2^ADDR_W; PRG_A wraps 255→0; step 0 is legal (fixed address).
- PRGW with DIR=1 is treated as PRGW=0.

## Timing
- Reset: all outputs 0, state IDLE; an in-flight transfer is dropped without writeback.
- BUS_A/BUS_WE/BUS_DO stable from BUS_REQ rise until the ACK cycle; BUS_REQ drops the CE cycle after ACK.
- ACK with BUS_REQ=0 is ignored.
- Minimum 2 CE cycles per word. START→first BUS_REQ: 1 cycle (D0→RAM) or 2 cycles (RAM→D0).
- BUSY rises the cycle after START and falls the cycle after DONE.
- All strobes are single CE cycle. CE=0 freezes state and holds outputs.

## Structure
- Add the state enum and the latched-command struct to SCUDSP_PKG. Reuse the package step function for ADDI.
- Single module, no sub-module: counters and FSM are tightly coupled.

## Test plan
- D0→RAM, RAMS=1, CNT=3, ADDI=1, RA0=0x100, ACK immediate → RAM_WE[1]/CT_INC[1] ×3, BUS_A 0x400/0x404/0x408, RA0_OUT=0x103, RA0_UPD once.
- RAM→D0, RAMS=2, CNT=2, ADDI=0, WA0=0x40, HOLD=1, 3-cycle ACK delay → two bus writes to 0x100 with RAM_Q data, no WA0_UPD.
- PRGW, CNT=0 → 256 PRG_WE pulses, PRG_A 0..255, BUSY ends after last word.
- RA0 at max word pointer, ADDI=7 → address wraps modulo 2^27.
- RST_N low mid-transfer → outputs 0 immediately; next START runs cleanly.
- START while BUSY, and CE toggling → second START ignored, word count unchanged.
